// File: rtl/queue_dispatcher_pkg.sv
// Shared definitions for the queue dispatcher and the round-robin reader:
// default geometry and the occupancy encodings of the 2-entry buffer.
package queue_dispatcher_pkg;

    localparam int DEFAULT_QUEUE_QUANTITY = 4;
    localparam int DEFAULT_DATA_BITS      = 8;

    // Buffer occupancy doubles as the controller state: the value is the word count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifoState_e;

endpackage

// File: rtl/dispatch_fifo2.sv
// Two-entry in-order word buffer; slot0 is always the head, slot1 the word behind it.
module dispatch_fifo2
    import queue_dispatcher_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [DATA_BITS-1:0] data_i,
    output fifoState_e           state_o,
    output logic [DATA_BITS-1:0] head_o
);

    fifoState_e            state_q, state_d;
    logic [DATA_BITS-1:0]  slot0_q, slot0_d;
    logic [DATA_BITS-1:0]  slot1_q, slot1_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            state_q <= state_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    // A pop shifts slot1 forward first; the new word then lands at the post-pop tail.
    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;

        if (pop_i) begin
            slot0_d = slot1_q;
        end
        if (push_i) begin
            if (state_q == EMPTY || (state_q == ONE && pop_i)) begin
                slot0_d = data_i;
            end else begin
                slot1_d = data_i;
            end
        end

        unique case (state_q)
            EMPTY: begin
                if (push_i) state_d = ONE;
            end
            ONE: begin
                if (push_i && !pop_i)      state_d = FULL;
                else if (pop_i && !push_i) state_d = EMPTY;
            end
            FULL: begin
                if (pop_i && !push_i) state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
    end

    assign state_o = state_q;
    assign head_o  = slot0_q;

endmodule

// File: rtl/queue_dispatcher.sv
// Routes each accepted word to the queue named by its top bits, in strict arrival
// order, with registered one-hot push strobes and a sticky overflow detector.
module queue_dispatcher
    import queue_dispatcher_pkg::*;
#(
    parameter int QUEUE_QUANTITY = DEFAULT_QUEUE_QUANTITY,
    parameter int DATA_BITS      = DEFAULT_DATA_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enb,
    input  logic                      valid_in,
    input  logic [DATA_BITS-1:0]      data_in,
    input  logic [QUEUE_QUANTITY-1:0] almost_full,
    input  logic [QUEUE_QUANTITY-1:0] buf_full,
    output logic [QUEUE_QUANTITY-1:0] push,
    output logic [DATA_BITS-1:0]      data_out,
    output logic                      pause,
    output logic                      overflow_err,
    output logic                      idle
);

    localparam int DEST_BITS = $clog2(QUEUE_QUANTITY);

    fifoState_e                 fifoState;
    logic [DATA_BITS-1:0]       headWord;
    logic [DEST_BITS-1:0]       headDest;
    logic                       accept;
    logic                       dispatch;

    logic [QUEUE_QUANTITY-1:0]  push_q, push_d;
    logic [DATA_BITS-1:0]       dataOut_q, dataOut_d;
    logic                       overflow_q, overflow_d;

    dispatch_fifo2 #(
        .DATA_BITS (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .pop_i   (dispatch),
        .data_i  (data_in),
        .state_o (fifoState),
        .head_o  (headWord)
    );

    assign headDest = headWord[DATA_BITS-1 -: DEST_BITS];
    assign pause    = (fifoState == FULL);
    assign idle     = (fifoState == EMPTY);
    assign accept   = valid_in && !pause && enb;
    assign dispatch = enb && (fifoState != EMPTY) && !almost_full[headDest];

    // Overflow looks at the strobe currently on the bus against the queues' full flags.
    always_comb begin
        push_d     = '0;
        dataOut_d  = dataOut_q;
        overflow_d = overflow_q | (|(push_q & buf_full));
        if (dispatch) begin
            push_d    = QUEUE_QUANTITY'(1) << headDest;
            dataOut_d = headWord;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            push_q     <= '0;
            dataOut_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            push_q     <= push_d;
            dataOut_q  <= dataOut_d;
            overflow_q <= overflow_d;
        end
    end

    assign push         = push_q;
    assign data_out     = dataOut_q;
    assign overflow_err = overflow_q;

endmodule

// File: doc/queue_dispatcher.md
QUEUE_DISPATCHER -- requirements
Module: queue_dispatcher

Interface
REQ-001 Parameter QUEUE_QUANTITY, default 4, is the number of destination queues, a power of two and at least 2.
REQ-002 Parameter DATA_BITS, default 8, is the word width, at least $clog2(QUEUE_QUANTITY)+1.
REQ-003 clk  input  1  is the single clock; all state changes occur on the rising edge.
REQ-004 rst  input  1  is a synchronous, active-low reset sampled on the rising edge of clk.
REQ-005 enb  input  1  is the block enable; when low, the block neither accepts nor dispatches words.
REQ-006 valid_in  input  1  indicates that data_in holds a word offered by upstream.
REQ-007 data_in  input  DATA_BITS  is the offered word; its top $clog2(QUEUE_QUANTITY) bits form the destination index.
REQ-008 almost_full  input  QUEUE_QUANTITY  is the per-queue almost-full flag; it is guaranteed to assert while at least one slot is still free.
REQ-009 buf_full  input  QUEUE_QUANTITY  is the per-queue full flag, used only for error detection.
REQ-010 push  output  QUEUE_QUANTITY  is a registered one-hot (or all-zero) write strobe to the queues.
REQ-011 data_out  output  DATA_BITS  is the registered word that is valid while push is nonzero.
REQ-012 pause  output  1  is backpressure to upstream; a word is accepted only while it is low.
REQ-013 overflow_err  output  1  is a sticky flag set when a push lands on a full queue.
REQ-014 idle  output  1  is high when the internal buffer holds no word.

Function
REQ-015 An internal 2-entry in-order buffer (count 0/1/2) shall hold accepted words; the count values act as the state machine states EMPTY, ONE and FULL.
REQ-016 Accept shall occur on a rising edge when valid_in=1, pause=0 and enb=1; the word is written at the tail.
REQ-017 Dispatch shall occur on a rising edge when count>0, enb=1 and almost_full[dest(head)]=0; on that edge push <= one-hot(dest(head)) and data_out <= the head word, and the head is popped.
REQ-018 On every edge without a dispatch, push <= 0 and data_out shall hold its previous value.
REQ-019 Accept and dispatch on the same edge shall leave count unchanged, giving throughput of 1 word per cycle.
REQ-020 Transitions: EMPTY->ONE on accept; ONE->FULL on accept without dispatch; ONE->EMPTY on dispatch without accept; FULL->ONE on dispatch; all other cases hold the current state.
REQ-021 pause shall equal (count==2), decoded from registered state only, with no combinational path from inputs.
REQ-022 Latency: a word presented while count=0 and unblocked shall have push high in the second cycle after it was presented (accept edge, then dispatch edge).
REQ-023 Order shall be strictly FIFO; a blocked head stalls all following words (head-of-line blocking is intended).
REQ-024 data_out shall carry the full word unmodified, including the destination bits.
REQ-025 overflow_err shall be set on any edge where push[i]=1 and buf_full[i]=1 for some i, and cleared only by reset.
REQ-026 When enb=0: no accept, no dispatch, push <= 0, and buffered contents and count are retained.
REQ-027 valid_in while pause=1 shall be ignored; upstream holds the word.

Reset
REQ-028 While rst=0 at an edge: count=0, push=0, data_out=0, overflow_err=0; consequently pause=0 and idle=1.
REQ-029 Reset mid-operation shall discard buffered words with no push emitted for them, and shall override any simultaneous accept or dispatch.

Structure
REQ-030 Default QUEUE_QUANTITY/DATA_BITS and the EMPTY/ONE/FULL encodings shall reside in a shared include file common with the round-robin reader.
REQ-031 The 2-entry buffer shall be one sub-module, dispatch_fifo2, providing push/pop/count/head; the top level holds the dispatch decision, output registers and error flag.

Verification
REQ-032 Reset with valid_in=1 -> push=0, pause=0, idle=1; after release, the word 8'hC5 (dest 3) gives push=4'b1000 and data_out=8'hC5 two cycles later.
REQ-033 Back-to-back words 8'h01, 8'h42, 8'h83, 8'hC4 with almost_full=0 -> push 0001, 0010, 0100, 1000 on consecutive cycles, and pause never asserts.
REQ-034 almost_full[1]=1, then send 8'h40 and 8'h05 -> count reaches 2, pause=1, no push; clearing almost_full[1] -> push 0010 (8'h40), then 0001 (8'h05), then pause=0.
REQ-035 Force buf_full[2]=1 while word 8'h80 is dispatched -> overflow_err=1 stays high until rst=0.
REQ-036 enb=0 with 2 words buffered -> push=0 and count retained; enb=1 -> both words drain in order; rst=0 while FULL -> buffer empties, and no push occurs for the discarded words.
